// File: rtl/nibbler_pkg.sv
// Shared constants and loader state encoding for the Nibbler program loader.
package nibbler_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int NIB_W      = 4;
    localparam int PROG_DEPTH = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_CHK_HI,
        S_CHK_LO,
        S_DONE
    } ldr_state_e;

endpackage

// File: rtl/nibbler_nib_packer.sv
// Nibble capture: holds the high nibble and presents the assembled byte.
module nibbler_nib_packer
    import nibbler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              take_hi,
    input  logic              nib_valid,
    input  logic              nib_ready,
    input  logic [NIB_W-1:0]  nib_data,
    output logic              fire,
    output logic [DATA_W-1:0] byte_out
);

    logic [NIB_W-1:0] hi_q;
    logic [NIB_W-1:0] hi_d;

    always_comb begin
        fire     = nib_valid & nib_ready;
        hi_d     = hi_q;
        if (fire && take_hi) begin
            hi_d = nib_data;
        end
        // Valid only on the low-nibble handshake; high half was captured earlier.
        byte_out = {hi_q, nib_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/nibbler_prog_loader.sv
// Nibbler program-memory loader: nibble stream in, sequential byte writes out.
// Optional checksum byte check enabled by NIBBLER_LOADER_CHECKSUM_EN.
module nibbler_prog_loader #(
    parameter int ADDR_W = nibbler_pkg::ADDR_W,
    parameter int DATA_W = nibbler_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    input  logic              nib_valid,
    input  logic [3:0]        nib_data,
    output logic              nib_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    import nibbler_pkg::*;

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy_q, rdy_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] last_addr;
    logic              fire;
    logic              take_hi;
    logic [DATA_W-1:0] pk_byte;
`ifdef NIBBLER_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign take_hi = (state_q == S_HI) || (state_q == S_CHK_HI);

    nibbler_nib_packer u_packer (
        .clk       (CLK),
        .rst       (RESET),
        .take_hi   (take_hi),
        .nib_valid (nib_valid),
        .nib_ready (rdy_q),
        .nib_data  (nib_data),
        .fire      (fire),
        .byte_out  (pk_byte)
    );

    // length==0 wraps to the top address, giving a full 4096-byte load.
    assign last_addr = len_q - ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef NIBBLER_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    len_d   = length;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
`ifdef NIBBLER_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_HI: begin
                if (fire) state_d = S_LO;
            end
            S_LO: begin
                if (fire) begin
                    wdata_d = pk_byte;
                    state_d = S_WR;
                end
            end
            S_WR: begin
`ifdef NIBBLER_LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
                if (cnt_q == last_addr) begin
`ifdef NIBBLER_LOADER_CHECKSUM_EN
                    state_d = S_CHK_HI;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
`ifdef NIBBLER_LOADER_CHECKSUM_EN
            S_CHK_HI: begin
                if (fire) state_d = S_CHK_LO;
            end
            S_CHK_LO: begin
                if (fire) begin
                    err_d   = (pk_byte != sum_q);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE && state_q != S_DONE) begin
            busy_d = 1'b0;
            hold_d = 1'b0;
            done_d = 1'b1;
        end

        we_d  = (state_d == S_WR);
        rdy_d = (state_d == S_HI) || (state_d == S_LO) ||
                (state_d == S_CHK_HI) || (state_d == S_CHK_LO);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef NIBBLER_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign nib_ready = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = cnt_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Scoreboard bench for nibbler_prog_loader: writes are queued when issued
// and checked by a negedge monitor; directed checks are posted to it too.
module tb_nibbler_prog_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [11:0] length;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

`ifdef NIBBLER_LOADER_CHECKSUM_EN
    localparam int CHK_CYC = 2;
`else
    localparam int CHK_CYC = 0;
`endif

    nibbler_prog_loader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .length    (length),
        .nib_valid (nib_valid),
        .nib_data  (nib_data),
        .nib_ready (nib_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] sb_q[$];
    string       pn_q[$];
    logic [31:0] pa_q[$];
    logic [31:0] pe_q[$];
    logic [7:0]  img[$];
    longint      t_start  = -1000;
    bit          hold_en  = 1'b0;
    int          exp_done = 0;
    int          done_cyc = -1;
    int          wr0      = 0;
    logic [11:0] last_wr  = '0;

    task automatic post(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        pn_q.push_back(nm);
        pa_q.push_back(act);
        pe_q.push_back(exp);
    endtask

    always @(negedge CLK) begin : monitor
        int          cyc;
        logic [19:0] e;
        string       nm;
        logic [31:0] a;
        logic [31:0] x;
        cyc = int'((longint'($time) - t_start + 5) / 10);
        if (mem_we === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL write: got %h@%h, required no write",
                         mem_wdata, mem_addr);
            end else begin
                e = sb_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got %h@%h, required %h@%h",
                             mem_wdata, mem_addr, e[7:0], e[19:8]);
                end
            end
            if (mem_addr == 12'h000) wr0++;
            last_wr = mem_addr;
        end
        if (cyc == 1) done_cyc = -1;
        if (done === 1'b1 && done_cyc < 0 && cyc > 0) done_cyc = cyc;
        if (hold_en && cyc >= 1 && cyc <= exp_done) begin
            n_checks++;
            if (cpu_hold !== (cyc < exp_done)) begin
                n_fail++;
                $display("FAIL cpu_hold cycle %0d: got %b, required %b",
                         cyc, cpu_hold, cyc < exp_done);
            end
        end
        while (pn_q.size() > 0) begin
            nm = pn_q.pop_front();
            a  = pa_q.pop_front();
            x  = pe_q.pop_front();
            n_checks++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL %s: got %0h, required %0h", nm, a, x);
            end
        end
    end

    task automatic pulse_start(input logic [11:0] len);
        start  = 1'b1;
        length = len;
        @(posedge CLK);
        t_start = longint'($time);
        #1;
        start = 1'b0;
    endtask

    task automatic poke_start();
        nib_valid = 1'b0;
        start     = 1'b1;
        length    = 12'd1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] d, input int stall,
                            input bit lo_wait);
        bit ok;
        nib_valid = 1'b0;
        for (int j = 0; j < stall; j++) begin
            @(negedge CLK);
            if (lo_wait) post("ready_while_wait", {31'b0, nib_ready}, 1);
            @(posedge CLK);
            #1;
        end
        nib_valid = 1'b1;
        nib_data  = d;
        ok        = 1'b0;
        for (int j = 0; j < 50 && !ok; j++) begin
            @(negedge CLK);
            ok = (nib_ready === 1'b1);
            @(posedge CLK);
            #1;
        end
        if (!ok) post("nib_accept_timeout", 0, 1);
        nib_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int j = 0; j < 50; j++) begin
            @(negedge CLK);
            if (done === 1'b1) break;
        end
        post("done", {31'b0, done}, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_load(input logic [11:0] len, input int stall,
                            input int poke, input bit corrupt);
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) begin
            sb_q.push_back({12'(i), img[i]});
            s = s + img[i];
        end
        pulse_start(len);
        foreach (img[i]) begin
            if (2 * i == poke) poke_start();
            send_nib(img[i][7:4], stall, 1'b0);
            if (2 * i + 1 == poke) poke_start();
            send_nib(img[i][3:0], stall, 1'b1);
        end
`ifdef NIBBLER_LOADER_CHECKSUM_EN
        if (corrupt) s = s + 8'h01;
        send_nib(s[7:4], stall, 1'b0);
        send_nib(s[3:0], stall, 1'b1);
        wait_done();
        post("error", {31'b0, error}, {31'b0, corrupt});
`else
        wait_done();
        post("error", {31'b0, error}, 0);
`endif
    endtask

    initial begin
        int w0;
        RESET     = 1'b1;
        start     = 1'b0;
        length    = '0;
        nib_valid = 1'b0;
        nib_data  = '0;
        #3;
        post("rst_outputs",
             {mem_addr, mem_wdata, mem_we, nib_ready, cpu_hold,
              busy, done, error}, 0);
        #20;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Three bytes, zero stall, exact cycle timing.
        img      = '{8'hA5, 8'h3C, 8'hF0};
        exp_done = 10 + CHK_CYC;
        hold_en  = 1'b1;
        run_load(12'd3, 0, -1, 1'b0);
        hold_en = 1'b0;
        post("done_cycle_3b", done_cyc, exp_done);
        post("busy_after", {31'b0, busy}, 0);

        // Same image with 4 idle cycles before every nibble.
        run_load(12'd3, 4, -1, 1'b0);
        post("sb_drained_stall", sb_q.size(), 0);

        // Spurious start in the middle of a byte.
        img = '{8'h11, 8'h22, 8'h33};
        run_load(12'd3, 0, 1, 1'b0);
        post("done_cycle_poke", done_cyc, 11 + CHK_CYC);

        // Full 4096-byte image via length==0.
        img.delete();
        for (int k = 0; k < 4096; k++) img.push_back(8'(k));
        w0 = wr0;
        run_load(12'd0, 0, -1, 1'b0);
        post("full_last_addr", {20'b0, last_wr}, 32'hFFF);
        post("full_addr0_once", wr0 - w0, 1);
        post("sb_drained_full", sb_q.size(), 0);

        // Reset while waiting for the low nibble of byte 3.
        sb_q.push_back({12'h000, 8'h12});
        sb_q.push_back({12'h001, 8'h34});
        sb_q.push_back({12'h002, 8'h56});
        pulse_start(12'd5);
        send_nib(4'h1, 0, 1'b0);
        send_nib(4'h2, 0, 1'b1);
        send_nib(4'h3, 0, 1'b0);
        send_nib(4'h4, 0, 1'b1);
        send_nib(4'h5, 0, 1'b0);
        send_nib(4'h6, 0, 1'b1);
        send_nib(4'h7, 0, 1'b0);
        post("pre_rst_hold", {31'b0, cpu_hold}, 1);
        RESET = 1'b1;
        #1;
        post("rst_mid_outputs",
             {mem_addr, mem_wdata, mem_we, nib_ready, cpu_hold,
              busy, done, error}, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        post("idle_ready", {31'b0, nib_ready}, 0);
        post("idle_busy", {31'b0, busy}, 0);
        img = '{8'h5A};
        run_load(12'd1, 0, -1, 1'b0);
        post("reload_addr", {20'b0, last_wr}, 0);

`ifdef NIBBLER_LOADER_CHECKSUM_EN
        img = '{8'h12, 8'h34};
        run_load(12'd2, 0, -1, 1'b0);
        run_load(12'd2, 0, -1, 1'b1);
`endif

        repeat (3) @(posedge CLK);
        post("sb_drained_end", sb_q.size(), 0);
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
